vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 144 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, h/v counters and phase FSMs, registered sync/enable outputs.
// Optional frame counter enabled by defining VGA_FRAME_CNT_EN; otherwise frame_cnt is tied to zero.
module vga_timing_gen #(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        CLK,
   input  logic        RST,
   output logic [31:0] row,
   output logic [31:0] col,
   output logic        hsync,
   output logic        vsync,
   output logic        vnotactive,
   output logic        de,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_VISIBLE + H_FP;
   localparam int HS_END   = H_VISIBLE + H_FP + H_SYNC;
   localparam int VS_START = V_VISIBLE + V_FP;
   localparam int VS_END   = V_VISIBLE + V_FP + V_SYNC;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [1:0] H_ACT    = 2'd0;
   localparam logic [1:0] H_FRONT  = 2'd1;
   localparam logic [1:0] H_SYNC_S = 2'd2;
   localparam logic [1:0] H_BACK   = 2'd3;
   localparam logic [1:0] V_ACT    = 2'd0;
   localparam logic [1:0] V_FRONT  = 2'd1;
   localparam logic [1:0] V_SYNC_S = 2'd2;
   localparam logic [1:0] V_BACK   = 2'd3;

   logic [DW-1:0] div;
   logic          pix_en;
   logic [HW-1:0] hcnt, hcnt_n;
   logic [VW-1:0] vcnt, vcnt_n;
   logic          line_end;
   logic          frame_end;
   logic [1:0]    h_state, h_state_n;
   logic [1:0]    v_state, v_state_n;

   assign pix_en    = (div == DW'(CLK_DIV - 1));
   assign line_end  = pix_en && (hcnt == HW'(H_TOTAL - 1));
   assign frame_end = line_end && (vcnt == VW'(V_TOTAL - 1));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         div <= '0;
      end else if (pix_en) begin
         div <= '0;
      end else begin
         div <= div + DW'(1);
      end
   end

   always_comb begin
      hcnt_n = hcnt;
      vcnt_n = vcnt;
      if (pix_en) begin
         hcnt_n = line_end ? '0 : hcnt + HW'(1);
      end
      if (line_end) begin
         vcnt_n = (vcnt == VW'(V_TOTAL - 1)) ? '0 : vcnt + VW'(1);
      end
   end

   // Phase FSMs move only when the next count crosses a boundary; every phase must be at least one unit long.
   always_comb begin
      h_state_n = h_state;
      if (pix_en) begin
         case (h_state)
            H_ACT:    if (hcnt_n == HW'(H_VISIBLE)) h_state_n = H_FRONT;
            H_FRONT:  if (hcnt_n == HW'(HS_START))  h_state_n = H_SYNC_S;
            H_SYNC_S: if (hcnt_n == HW'(HS_END))    h_state_n = H_BACK;
            default:  if (hcnt_n == '0)             h_state_n = H_ACT;
         endcase
      end
   end

   always_comb begin
      v_state_n = v_state;
      if (line_end) begin
         case (v_state)
            V_ACT:    if (vcnt_n == VW'(V_VISIBLE)) v_state_n = V_FRONT;
            V_FRONT:  if (vcnt_n == VW'(VS_START))  v_state_n = V_SYNC_S;
            V_SYNC_S: if (vcnt_n == VW'(VS_END))    v_state_n = V_BACK;
            default:  if (vcnt_n == '0)             v_state_n = V_ACT;
         endcase
      end
   end

   // Counters, states and decoded outputs all load from the same next values, so they never skew.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         hcnt        <= '0;
         vcnt        <= '0;
         h_state     <= H_ACT;
         v_state     <= V_ACT;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         vnotactive  <= 1'b0;
         de          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         hcnt        <= hcnt_n;
         vcnt        <= vcnt_n;
         h_state     <= h_state_n;
         v_state     <= v_state_n;
         hsync       <= (h_state_n != H_SYNC_S);
         vsync       <= (v_state_n != V_SYNC_S);
         vnotactive  <= (v_state_n != V_ACT);
         de          <= (h_state_n == H_ACT) && (v_state_n == V_ACT);
         frame_start <= frame_end;
      end
   end

   assign row = 32'(vcnt);
   assign col = 32'(hcnt);

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         frame_cnt <= '0;
      end else if (frame_end) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`else
   assign frame_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default-size instance for horizontal timing, reduced-size instances
// for vertical, frame-wrap, reset-abort and CLK_DIV=1 frame-period behaviour.
module tb_vga_timing_gen;

   logic CLK = 1'b0;
   logic RST = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Default-parameter instance
   logic [31:0] row_d, col_d;
   logic        hs_d, vs_d, vna_d, de_d, fs_d;
   logic [15:0] fc_d;
   // Reduced frame: H 8/2/3/2 (15), V 6/2/2/3 (13), CLK_DIV=2
   logic [31:0] row_s, col_s;
   logic        hs_s, vs_s, vna_s, de_s, fs_s;
   logic [15:0] fc_s;
   // Same reduced frame at CLK_DIV=1
   logic [31:0] row_f, col_f;
   logic        hs_f, vs_f, vna_f, de_f, fs_f;
   logic [15:0] fc_f;

   vga_timing_gen u_d (
      .CLK(CLK), .RST(RST), .row(row_d), .col(col_d), .hsync(hs_d), .vsync(vs_d),
      .vnotactive(vna_d), .de(de_d), .frame_start(fs_d), .frame_cnt(fc_d)
   );

   vga_timing_gen #(
      .CLK_DIV(2), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_s (
      .CLK(CLK), .RST(RST), .row(row_s), .col(col_s), .hsync(hs_s), .vsync(vs_s),
      .vnotactive(vna_s), .de(de_s), .frame_start(fs_s), .frame_cnt(fc_s)
   );

   vga_timing_gen #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) u_f (
      .CLK(CLK), .RST(RST), .row(row_f), .col(col_f), .hsync(hs_f), .vsync(vs_f),
      .vnotactive(vna_f), .de(de_f), .frame_start(fs_f), .frame_cnt(fc_f)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic wait_d_col(input int target);
      int n = 0;
      while (col_d != 32'(target) && n < 2000) begin
         @(negedge CLK);
         n++;
      end
      chk("reach_col_d", col_d, 32'(target));
   endtask

   task automatic wait_s(input int r, input int c);
      int n = 0;
      while ((row_s != 32'(r) || col_s != 32'(c)) && n < 1000) begin
         @(negedge CLK);
         n++;
      end
      chk("reach_row_s", row_s, 32'(r));
      chk("reach_col_s", col_s, 32'(c));
   endtask

   initial begin
      logic [15:0] fc_before;
      logic [15:0] fc_exp;
      int          n;

      // Reset held: every output at its reset value
      repeat (3) @(negedge CLK);
      chk("rst_row", row_d, 0);
      chk("rst_col", col_d, 0);
      chk("rst_hsync", hs_d, 1);
      chk("rst_vsync", vs_d, 1);
      chk("rst_de", de_d, 1);
      chk("rst_vnotactive", vna_d, 0);
      chk("rst_frame_start", fs_d, 0);
      chk("rst_frame_cnt", fc_d, 0);

      // Release: col steps every 2nd CLK, first pix_en on the CLK_DIV-th edge
      RST = 1'b1;
      @(negedge CLK);
      chk("rel1_col", col_d, 0);
      chk("rel1_col_div1", col_f, 1);
      chk("rel1_fs", fs_d, 0);
      @(negedge CLK);
      chk("rel2_col", col_d, 1);
      chk("rel2_fs_div1", fs_f, 0);
      @(negedge CLK);
      chk("rel3_col_hold", col_d, 1);
      @(negedge CLK);
      chk("rel4_col", col_d, 2);
      chk("rel4_row", row_d, 0);
      chk("rel4_de", de_d, 1);
      chk("rel4_hsync", hs_d, 1);

      // Horizontal phases on the default timing
      wait_d_col(639);
      chk("c639_de", de_d, 1);
      wait_d_col(640);
      chk("c640_de", de_d, 0);
      chk("c640_hsync", hs_d, 1);
      wait_d_col(655);
      chk("c655_hsync", hs_d, 1);
      wait_d_col(656);
      chk("c656_hsync", hs_d, 0);
      wait_d_col(751);
      chk("c751_hsync", hs_d, 0);
      wait_d_col(752);
      chk("c752_hsync", hs_d, 1);
      wait_d_col(799);
      chk("c799_row", row_d, 0);
      wait_d_col(0);
      chk("line1_row", row_d, 1);
      chk("line1_de", de_d, 1);
      chk("line1_vsync", vs_d, 1);

      // Vertical phases on the reduced frame
      wait_s(5, 7);
      chk("s5_7_vna", vna_s, 0);
      chk("s5_7_de", de_s, 1);
      wait_s(6, 0);
      chk("s6_0_vna", vna_s, 1);
      chk("s6_0_de", de_s, 0);
      chk("s6_0_vsync", vs_s, 1);
      wait_s(8, 0);
      chk("s8_0_vsync", vs_s, 0);
      chk("s8_0_de", de_s, 0);
      wait_s(8, 14);
      chk("s8_14_vsync", vs_s, 0);
      wait_s(9, 7);
      chk("s9_7_vsync", vs_s, 0);
      chk("s9_7_de", de_s, 0);
      wait_s(10, 0);
      chk("s10_0_vsync", vs_s, 1);
      chk("s10_0_vna", vna_s, 1);
      wait_s(12, 14);
      chk("s12_14_vna", vna_s, 1);
      chk("s12_14_fs", fs_s, 0);
      fc_before = fc_s;

      // Frame wrap: (14,12) -> (0,0), frame_start for exactly one CLK
      n = 0;
      while (col_s != 0 && n < 4) begin
         @(negedge CLK);
         n++;
      end
      chk("wrap_col", col_s, 0);
      chk("wrap_row", row_s, 0);
      chk("wrap_fs", fs_s, 1);
      chk("wrap_de", de_s, 1);
`ifdef VGA_FRAME_CNT_EN
      fc_exp = fc_before + 16'd1;
`else
      fc_exp = 16'h0;
`endif
      chk("wrap_frame_cnt", fc_s, fc_exp);
      @(negedge CLK);
      chk("wrap_fs_drop", fs_s, 0);
      chk("wrap_col_hold", col_s, 0);

      // CLK_DIV=1 frame period: 15*13 = 195 CLK between frame_start pulses
      n = 0;
      while (fs_f != 1'b1 && n < 400) begin
         @(negedge CLK);
         n++;
      end
      chk("div1_first_fs", fs_f, 1);
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (fs_f != 1'b1 && n < 400);
      chk("div1_frame_period", 32'(n), 195);

      // Reset mid-frame aborts at once and restarts from (0,0)
      wait_s(4, 5);
      RST = 1'b0;
      #1;
      chk("abort_row", row_s, 0);
      chk("abort_col", col_s, 0);
      chk("abort_hsync", hs_s, 1);
      chk("abort_vsync", vs_s, 1);
      chk("abort_de", de_s, 1);
      chk("abort_vna", vna_s, 0);
      chk("abort_fs", fs_s, 0);
      chk("abort_fc", fc_s, 0);
      repeat (3) @(negedge CLK);
      chk("abort_hold_col", col_s, 0);
      RST = 1'b1;
      @(negedge CLK);
      chk("resume1_col", col_s, 0);
      chk("resume1_fs", fs_s, 0);
      @(negedge CLK);
      chk("resume2_col", col_s, 1);
      chk("resume2_row", row_s, 0);
      chk("resume2_fs", fs_s, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
